// File: rtl/parity_engine_pkg.sv
// Shared definitions for the AXI4-Lite parity engine.
//   - Register byte offsets (word aligned, DATA[i] at OFF_DATA + 4*i)
//   - AXI response codes
//   - Sequencer state encoding
//   - strb_mask(): expands a 4-bit byte strobe into a 32-bit bit mask
package parity_engine_pkg;

   localparam int MAX_CH = 16;

   localparam logic [7:0] OFF_CTRL     = 8'h00;
   localparam logic [7:0] OFF_STATUS   = 8'h04;
   localparam logic [7:0] OFF_RESULT   = 8'h08;
   localparam logic [7:0] OFF_EXPECT   = 8'h0C;
   localparam logic [7:0] OFF_MISMATCH = 8'h10;
   localparam logic [7:0] OFF_DATA     = 8'h20;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      FIN  = 2'd2
   } state_e;

   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{strb[b]}};
      return m;
   endfunction

endpackage

// File: rtl/parity_engine_axil_if.sv
// AXI4-Lite slave handshake front end for the parity engine.
//   S_AXI_*  : AXI4-Lite slave port (AWPROT/ARPROT ignored)
//   wr_en    : one-cycle write strobe, qualified with wr_addr/wr_data/wr_strb
//   wr_err   : returned combinationally by the register file during wr_en
//   rd_addr  : read address, valid in the cycle ARREADY is high
//   rd_data/rd_err : returned combinationally by the register file
// AWREADY/WREADY and ARREADY are registered single-cycle pulses; the write
// strobe and read capture happen in the cycle those pulses are high.
module parity_engine_axil_if
   import parity_engine_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 7
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [3:0]                      S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            wr_en,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_addr,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data,
   output logic [3:0]                      wr_strb,
   input  logic                            wr_err,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]   rd_addr,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   rd_data,
   input  logic                            rd_err
);

   logic aw_ready_q;
   logic ar_ready_q;
   logic rd_en;
   logic unused_prot;

   assign S_AXI_AWREADY = aw_ready_q;
   assign S_AXI_WREADY  = aw_ready_q;
   assign S_AXI_ARREADY = ar_ready_q;

   assign wr_en   = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
   assign wr_addr = S_AXI_AWADDR;
   assign wr_data = S_AXI_WDATA;
   assign wr_strb = S_AXI_WSTRB;

   assign rd_en   = ar_ready_q & S_AXI_ARVALID;
   assign rd_addr = S_AXI_ARADDR;

   assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_ready_q   <= 1'b0;
         ar_ready_q   <= 1'b0;
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP  <= RESP_OKAY;
         S_AXI_RVALID <= 1'b0;
         S_AXI_RRESP  <= RESP_OKAY;
         S_AXI_RDATA  <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples
         // pre-edge values; the ready terms below depend on that.
         // The !ready term turns a held request into a single-cycle pulse.
         aw_ready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID & ~aw_ready_q;
         ar_ready_q <= S_AXI_ARVALID & ~S_AXI_RVALID & ~ar_ready_q;

         if (wr_en) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_err ? RESP_SLVERR : RESP_OKAY;
         end else if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
         end

         if (rd_en) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_data;
            S_AXI_RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
         end else if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/parity_engine_axil.sv
// AXI4-Lite parity engine: NUM_CH data words of DATA_W bits, one channel
// scanned per clock, per-channel parity compared against EXPECT with a
// saturating cumulative mismatch counter.
//   ACLK/ARESET : clock, asynchronous active-high reset
//   S_AXI_*     : AXI4-Lite slave port (see parity_engine_axil_if)
//   irq         : level interrupt, DONE & IRQ_EN
module parity_engine_axil
   import parity_engine_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 7,
   parameter int NUM_CH             = 4,
   parameter int DATA_W             = 32
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [3:0]                      S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            irq
);

   localparam int AW    = C_S_AXI_ADDR_WIDTH;
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

   logic                          wr_en, wr_err, rd_err;
   logic [AW-1:0]                 wr_addr, rd_addr;
   logic [C_S_AXI_DATA_WIDTH-1:0] wr_data, rd_data;
   logic [3:0]                    wr_strb;

   parity_engine_axil_if #(
      .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
      .C_S_AXI_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH)
   ) u_if (
      .ACLK (ACLK), .ARESET (ARESET),
      .S_AXI_AWADDR (S_AXI_AWADDR), .S_AXI_AWPROT (S_AXI_AWPROT),
      .S_AXI_AWVALID (S_AXI_AWVALID), .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA (S_AXI_WDATA), .S_AXI_WSTRB (S_AXI_WSTRB),
      .S_AXI_WVALID (S_AXI_WVALID), .S_AXI_WREADY (S_AXI_WREADY),
      .S_AXI_BRESP (S_AXI_BRESP), .S_AXI_BVALID (S_AXI_BVALID),
      .S_AXI_BREADY (S_AXI_BREADY),
      .S_AXI_ARADDR (S_AXI_ARADDR), .S_AXI_ARPROT (S_AXI_ARPROT),
      .S_AXI_ARVALID (S_AXI_ARVALID), .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA (S_AXI_RDATA), .S_AXI_RRESP (S_AXI_RRESP),
      .S_AXI_RVALID (S_AXI_RVALID), .S_AXI_RREADY (S_AXI_RREADY),
      .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
      .wr_strb (wr_strb), .wr_err (wr_err),
      .rd_addr (rd_addr), .rd_data (rd_data), .rd_err (rd_err)
   );

   state_e                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q;
   logic                      ctrl_odd_q, ctrl_irq_en_q, done_q;
   logic [NUM_CH-1:0]         expect_q, result_q;
   logic [15:0]               mis_cnt_q;
   logic [DATA_W-1:0]         data_q [NUM_CH];

   logic [7:0]                wr_off, rd_off;
   logic                      sel_ctrl, sel_status, sel_result, sel_expect, sel_mis;
   logic [NUM_CH-1:0]         sel_data;
   logic                      wr_hit, wr_ok, busy, start, par_bit, mis_bit;
   logic [31:0]               wmask;
   logic                      unused_addr_bits;

   // Byte offsets with addr[1:0] dropped, so any byte lane hits the word.
   assign wr_off = 8'({wr_addr[AW-1:2], 2'b00});
   assign rd_off = 8'({rd_addr[AW-1:2], 2'b00});
   assign unused_addr_bits = ^{wr_addr[1:0], rd_addr[1:0]};

   assign busy = (state_q != IDLE);
   assign irq  = done_q & ctrl_irq_en_q;

   assign sel_ctrl   = (wr_off == OFF_CTRL);
   assign sel_status = (wr_off == OFF_STATUS);
   assign sel_result = (wr_off == OFF_RESULT);
   assign sel_expect = (wr_off == OFF_EXPECT);
   assign sel_mis    = (wr_off == OFF_MISMATCH);

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      sel_data = '0;
      for (int i = 0; i < NUM_CH; i++) sel_data[i] = (wr_off == OFF_DATA + 8'(4 * i));
   end

   assign wr_hit = sel_ctrl | sel_status | sel_result | sel_expect | sel_mis | (|sel_data);
   // STATUS W1C and the read-only RESULT stay usable while the scan runs.
   assign wr_err = ~wr_hit | (busy & ~(sel_status | sel_result));
   assign wr_ok  = wr_en & ~wr_err;
   assign start  = wr_ok & sel_ctrl & wr_strb[0] & wr_data[0];
   assign wmask  = strb_mask(wr_strb);

   assign par_bit = (^data_q[idx_q]) ^ ctrl_odd_q;
   assign mis_bit = (par_bit != expect_q[idx_q]);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SCAN;
         SCAN:    if (idx_q == LAST_IDX) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         ctrl_odd_q    <= 1'b0;
         ctrl_irq_en_q <= 1'b0;
         done_q        <= 1'b0;
         expect_q      <= '0;
         result_q      <= '0;
         mis_cnt_q     <= '0;
         // NOTE: the data words are reset too: a reset must leave DATA
         // reading 0, so this array cannot map onto reset-less RAM.
         for (int i = 0; i < NUM_CH; i++) data_q[i] <= '0;
      end else begin
         state_q <= state_d;

         if (wr_ok && sel_ctrl && wr_strb[0]) begin
            ctrl_odd_q    <= wr_data[1];
            ctrl_irq_en_q <= wr_data[2];
         end

         if (start) begin
            idx_q <= '0;
         end else if (state_q == SCAN) begin
            idx_q           <= idx_q + IDX_W'(1);
            result_q[idx_q] <= par_bit;
            if (mis_bit && (mis_cnt_q != 16'hFFFF)) mis_cnt_q <= mis_cnt_q + 16'd1;
         end

         // Counter clear cannot collide with a scan increment: the clear
         // is refused while busy.
         if (wr_ok && sel_mis) mis_cnt_q <= '0;

         if (wr_ok && sel_expect)
            expect_q <= NUM_CH'((32'(expect_q) & ~wmask) | (wr_data & wmask));

         for (int i = 0; i < NUM_CH; i++)
            if (wr_ok && sel_data[i])
               data_q[i] <= DATA_W'((32'(data_q[i]) & ~wmask) | (wr_data & wmask));

         // Order matters: a FIN set lands after a same-cycle W1C and wins.
         if (start || (wr_ok && sel_status && wr_strb[0] && wr_data[1])) done_q <= 1'b0;
         if (state_q == FIN) done_q <= 1'b1;
      end
   end

   always_comb begin
      rd_data = '0;
      rd_err  = 1'b0;
      case (rd_off)
         OFF_CTRL:     rd_data = {29'd0, ctrl_irq_en_q, ctrl_odd_q, 1'b0};
         OFF_STATUS:   rd_data = {30'd0, done_q, busy};
         OFF_RESULT:   rd_data = 32'(result_q);
         OFF_EXPECT:   rd_data = 32'(expect_q);
         OFF_MISMATCH: rd_data = {16'd0, mis_cnt_q};
         default: begin
            rd_err = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
               if (rd_off == OFF_DATA + 8'(4 * i)) begin
                  rd_data = 32'(data_q[i]);
                  rd_err  = 1'b0;
               end
            end
         end
      endcase
   end

endmodule

// File: tb/tb_parity_engine_axil.sv
// Directed self-checking bench for parity_engine_axil (NUM_CH=4, DATA_W=32).
module tb_parity_engine_axil;
   import parity_engine_pkg::*;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [6:0]  s_awaddr = '0, s_araddr = '0;
   logic [2:0]  s_awprot = '0, s_arprot = '0;
   logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b1;
   logic        s_arvalid = 1'b0, s_rready = 1'b1;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_wstrb = '0;
   logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid, irq;
   logic [1:0]  s_bresp, s_rresp;
   logic [31:0] s_rdata;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] rd;
   logic [1:0]  rsp;

   always #5 aclk = ~aclk;

   parity_engine_axil dut (
      .ACLK (aclk), .ARESET (areset),
      .S_AXI_AWADDR (s_awaddr), .S_AXI_AWPROT (s_awprot),
      .S_AXI_AWVALID (s_awvalid), .S_AXI_AWREADY (s_awready),
      .S_AXI_WDATA (s_wdata), .S_AXI_WSTRB (s_wstrb),
      .S_AXI_WVALID (s_wvalid), .S_AXI_WREADY (s_wready),
      .S_AXI_BRESP (s_bresp), .S_AXI_BVALID (s_bvalid), .S_AXI_BREADY (s_bready),
      .S_AXI_ARADDR (s_araddr), .S_AXI_ARPROT (s_arprot),
      .S_AXI_ARVALID (s_arvalid), .S_AXI_ARREADY (s_arready),
      .S_AXI_RDATA (s_rdata), .S_AXI_RRESP (s_rresp),
      .S_AXI_RVALID (s_rvalid), .S_AXI_RREADY (s_rready),
      .irq (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with AW/W already presented.
   task automatic wait_bresp(output logic [1:0] resp);
      int n;
      n = 0;
      do begin @(negedge aclk); n++; end while (!s_awready && n < 32);
      if (!s_awready) check("aw_timeout", 32'(s_awready), 32'd1);
      @(negedge aclk);
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      n = 0;
      while (!s_bvalid && n < 32) begin @(negedge aclk); n++; end
      if (!s_bvalid) check("b_timeout", 32'(s_bvalid), 32'd1);
      resp = s_bresp;
   endtask

   task automatic axi_write(input logic [6:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
      s_awaddr = a; s_wdata = d; s_wstrb = s;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      wait_bresp(resp);
   endtask

   task automatic axi_read(input logic [6:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      s_araddr = a; s_arvalid = 1'b1;
      n = 0;
      do begin @(negedge aclk); n++; end while (!s_arready && n < 32);
      if (!s_arready) check("ar_timeout", 32'(s_arready), 32'd1);
      @(negedge aclk);
      s_arvalid = 1'b0;
      n = 0;
      while (!s_rvalid && n < 32) begin @(negedge aclk); n++; end
      if (!s_rvalid) check("r_timeout", 32'(s_rvalid), 32'd1);
      d = s_rdata; resp = s_rresp;
   endtask

   task automatic wr_check(input string tag, input logic [6:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] exp_resp);
      logic [1:0] r;
      axi_write(a, d, s, r);
      check(tag, 32'(r), 32'(exp_resp));
   endtask

   task automatic rd_check(input string tag, input logic [6:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic [1:0]  r;
      axi_read(a, d, r);
      check({tag, "_data"}, d, exp);
      check({tag, "_resp"}, 32'(r), 32'(RESP_OKAY));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset state ----
      repeat (3) @(negedge aclk);
      check("rst0_hs", 32'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, irq}), 32'd0);
      check("rst0_rdata", s_rdata, 32'd0);
      areset = 1'b0;
      @(negedge aclk);
      rd_check("rst_status", 7'h04, 32'h0);
      rd_check("rst_result", 7'h08, 32'h0);
      rd_check("rst_miscnt", 7'h10, 32'h0);
      check("rst_irq", 32'(irq), 32'd0);

      // ---- even parity run: DATA=1,2,3,4 -> RESULT=0xB ----
      wr_check("wr_data0", 7'h20, 32'd1, 4'hF, RESP_OKAY);
      axi_write(7'h24, 32'd2, 4'hF, rsp);
      axi_write(7'h28, 32'd3, 4'hF, rsp);
      axi_write(7'h2C, 32'd4, 4'hF, rsp);
      wr_check("wr_expect", 7'h0C, 32'hB, 4'hF, RESP_OKAY);
      wr_check("start_even", 7'h00, 32'h5, 4'hF, RESP_OKAY);   // returns at T+1
      repeat (4) @(negedge aclk);                              // T+5
      check("irq_t5", 32'(irq), 32'd0);
      @(negedge aclk);                                         // T+6
      check("irq_t6", 32'(irq), 32'd1);
      rd_check("even_status", 7'h04, 32'h2);
      rd_check("even_result", 7'h08, 32'hB);
      rd_check("even_miscnt", 7'h10, 32'h0);
      wr_check("w1c_done", 7'h04, 32'h2, 4'hF, RESP_OKAY);
      check("irq_w1c", 32'(irq), 32'd0);
      rd_check("status_w1c", 7'h04, 32'h0);

      // ---- odd parity run: RESULT=0x4, 4 mismatches, no irq ----
      wr_check("start_odd", 7'h00, 32'h3, 4'hF, RESP_OKAY);
      rd_check("odd_busy", 7'h04, 32'h1);
      repeat (8) @(negedge aclk);
      check("odd_irq", 32'(irq), 32'd0);
      rd_check("odd_status", 7'h04, 32'h2);
      rd_check("odd_result", 7'h08, 32'h4);
      rd_check("odd_miscnt", 7'h10, 32'h4);

      // ---- second START while busy: refused, DONE timing unchanged ----
      wr_check("start_a", 7'h00, 32'h5, 4'hF, RESP_OKAY);      // T+1
      wr_check("start_busy", 7'h00, 32'h5, 4'hF, RESP_SLVERR); // accepted T+3, back at T+4
      @(negedge aclk);                                         // T+5
      check("irq_b_t5", 32'(irq), 32'd0);
      @(negedge aclk);                                         // T+6
      check("irq_b_t6", 32'(irq), 32'd1);
      rd_check("b_result", 7'h08, 32'hB);
      rd_check("b_miscnt", 7'h10, 32'h4);

      // ---- DATA write while busy: SLVERR, no effect ----
      wr_check("start_c", 7'h00, 32'h1, 4'hF, RESP_OKAY);
      wr_check("data_busy", 7'h20, 32'hFF, 4'hF, RESP_SLVERR);
      repeat (8) @(negedge aclk);
      rd_check("data0_kept", 7'h20, 32'd1);

      // ---- counter clear and byte enables ----
      wr_check("mis_clr", 7'h10, 32'h1234, 4'hF, RESP_OKAY);
      rd_check("mis_zero", 7'h10, 32'h0);
      wr_check("data1_strb", 7'h24, 32'hAABBCCDD, 4'b0010, RESP_OKAY);
      rd_check("data1_byte", 7'h24, 32'h0000CC02);

      // ---- BREADY held low: BVALID/BRESP hold, no new write accepted ----
      s_bready = 1'b0;
      s_awaddr = 7'h0C; s_wdata = 32'hB; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      begin
         int n;
         n = 0;
         do begin @(negedge aclk); n++; end while (!s_awready && n < 32);
         if (!s_awready) check("bp_aw_timeout", 32'(s_awready), 32'd1);
      end
      @(negedge aclk);
      s_awaddr = 7'h7C;   // next write presented while BVALID is pending
      for (int k = 0; k < 3; k++) begin
         @(negedge aclk);
         check("bp_bvalid", 32'(s_bvalid), 32'd1);
         check("bp_bresp", 32'(s_bresp), 32'(RESP_OKAY));
         check("bp_awready", 32'(s_awready), 32'd0);
      end
      s_bready = 1'b1;
      wait_bresp(rsp);
      check("unmapped_wr", 32'(rsp), 32'(RESP_SLVERR));
      axi_read(7'h7C, rd, rsp);
      check("unmapped_rd_resp", 32'(rsp), 32'(RESP_SLVERR));
      check("unmapped_rd_data", rd, 32'h0);

      // ---- reset at T+3 of a run, with BVALID and RVALID pending ----
      s_bready = 1'b0;
      axi_write(7'h00, 32'h1, 4'hF, rsp);                      // back at T+1
      s_araddr = 7'h20; s_arvalid = 1'b1; s_rready = 1'b0;
      @(negedge aclk);                                         // T+2
      @(negedge aclk);                                         // T+3
      s_arvalid = 1'b0;
      check("pre_rst_valids", 32'({s_bvalid, s_rvalid}), 32'h3);
      check("pre_rst_rdata", s_rdata, 32'd1);
      areset = 1'b1;
      #1;
      check("rst_hs", 32'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, irq}), 32'd0);
      check("rst_resps", 32'({s_bresp, s_rresp}), 32'd0);
      check("rst_rdata", s_rdata, 32'd0);
      @(negedge aclk);
      areset = 1'b0;
      s_bready = 1'b1;
      s_rready = 1'b1;
      @(negedge aclk);
      rd_check("post_status", 7'h04, 32'h0);
      rd_check("post_result", 7'h08, 32'h0);
      rd_check("post_data0", 7'h20, 32'h0);
      rd_check("post_miscnt", 7'h10, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/parity_engine_axil.md
# parity_engine_axil

Parametrised AXI4-Lite parity engine, next generation of the team's 4-register parity generator IP. Holds NUM_CH data words of DATA_W bits, computes even or odd parity per channel with a sequencer running one channel per clock, and compares the results against a software-loaded expected vector. It keeps a saturating mismatch count and raises a level interrupt on completion. It sits behind the PS AXI interconnect as a memory-mapped slave.

## Interface
- C_S_AXI_DATA_WIDTH, 32: bus data width; fixed, only 32 supported.
- C_S_AXI_ADDR_WIDTH, 7: byte address width; covers map up to 0x5C.
- NUM_CH, 4: channel count, 1..16.
- DATA_W, 32: channel data width, 1..32.
- ACLK  in  1  single clock, all logic rising-edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  C_S_AXI_ADDR_WIDTH/3/1/1  write address channel; AWPROT ignored.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  C_S_AXI_ADDR_WIDTH/3/1/1  read address; ARPROT ignored.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data.
- irq  out  1  DONE & IRQ_EN, level.

## Operation
- Register map (word aligned, addr[1:0] ignored):
  - 0x00 CTRL: b0 START (write-1 pulse, reads 0), b1 ODD, b2 IRQ_EN.
  - 0x04 STATUS: b0 BUSY (RO), b1 DONE (W1C).
  - 0x08 RESULT (RO): bits[NUM_CH-1:0].
  - 0x0C EXPECT (RW): bits[NUM_CH-1:0].
  - 0x10 MISMATCH_CNT (RO [15:0]): any write clears it.
  - 0x20+4*i DATA[i] (RW): bits ≥ DATA_W read 0.
- Per-channel result: RESULT[i] = ^DATA[i][DATA_W-1:0] ^ ODD.
- Mismatch count increments by 1 per scanned channel where RESULT[i] != EXPECT[i]. Cumulative across runs. Saturates at 0xFFFF.
- FSM states:
  - IDLE → SCAN on an accepted CTRL write with WSTRB[0] and WDATA[0]=1. Index clears to 0 and DONE clears.
  - SCAN: each cycle processes channel idx; idx increments. Leaves after idx=NUM_CH-1 → FIN.
  - FIN: sets DONE for one cycle, then → IDLE.
- BUSY = (state != IDLE).
- Writes while BUSY complete with BRESP=SLVERR (2'b10) and have no effect. This covers CTRL/START, EXPECT, DATA and MISMATCH_CNT. STATUS W1C is exempt.
- Byte enables: WSTRB is honoured on DATA and EXPECT. CTRL acts only when WSTRB[0]=1.
- Unmapped addresses:
  - Write: SLVERR, no effect.
  - Read: SLVERR, RDATA=0.
- If DONE set (FIN) and a DONE W1C land in the same cycle, set wins.

## Timing
- Reset values:
  - All AXI outputs 0: AWREADY, WREADY, BVALID, ARREADY, RVALID, BRESP, RRESP, RDATA.
  - irq 0; all registers 0; FSM IDLE.
- ARESET mid-scan aborts immediately. RESULT, count and DATA return to 0.
- Write path:
  - AWREADY and WREADY pulse together for 1 cycle when AWVALID & WVALID & !BVALID.
  - BVALID rises the next cycle and holds until BREADY.
  - No new write is accepted while BVALID=1.
- Read path:
  - ARREADY pulses 1 cycle when ARVALID & !RVALID.
  - RVALID and RDATA register the next cycle and hold stable until RREADY.
- START latency: START accepted at cycle T.
  - BUSY reads 1 from T+1.
  - RESULT[i] is written at the end of cycle T+1+i.
  - DONE=1 and irq (if IRQ_EN) at T+2+NUM_CH.
  - BUSY=0 at T+2+NUM_CH.

## Structure
- Package parity_engine_pkg holds:
  - register offset localparams;
  - state enum {IDLE, SCAN, FIN};
  - RESP_OKAY/RESP_SLVERR constants;
  - MAX_CH=16.
- Sub-module parity_engine_axil_if owns the AXI4-Lite handshakes. It presents a one-cycle wr_en/wr_addr/wr_data/wr_strb strobe with a wr_err return, plus rd_addr → rd_data/rd_err.
- The top level holds the register file, sequencer and counter.

## Test plan
- Reset release: read STATUS, RESULT and MISMATCH_CNT → all 0, RRESP OKAY, irq=0.
- Even parity run:
  - Stimulus: NUM_CH=4, DATA=1,2,3,4, EXPECT=0xB, CTRL=0x5.
  - BUSY=1 at T+1. DONE and irq at T+6.
  - RESULT=0xB, MISMATCH_CNT=0.
  - W1C DONE drops irq.
- Odd parity run: CTRL=0x3 with the same data → RESULT=0x4, MISMATCH_CNT=4, irq stays 0.
- Writes while BUSY:
  - DATA[0]=0xFF → BRESP=2'b10, readback still 1.
  - START again → ignored; DONE still at T+6.
- Protocol checks:
  - Hold BREADY low 3 cycles → BVALID and BRESP held, AWREADY stays 0.
  - Read 0x7C → RRESP=2'b10, RDATA=0.
- Assert ARESET at T+3 of a run → all outputs 0 asynchronously. After release, STATUS=0 and RESULT=0.
